// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write-back port.
// One write accepted per cycle; winner registered into the output stage.
module regfile_wb_arbiter #(
    parameter int NREQ        = 3,
    parameter int DATAWIDTH   = 32,
    parameter int ADDRWIDTH   = 5,
    parameter int ZERO_REG_EN = 1,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr_i,
    input  logic [NREQ*DATAWIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      rf_we_o,
    output logic [ADDRWIDTH-1:0]      rf_waddr_o,
    output logic [DATAWIDTH-1:0]      rf_wdata_o,
    output logic [IW-1:0]             grant_idx_o
);

    logic [IW-1:0]        ptr;
    logic [IW-1:0]        win;
    logic                 found;
    logic                 grant;
    logic [ADDRWIDTH-1:0] win_addr;
    logic [DATAWIDTH-1:0] win_data;
    int unsigned          idx;

    // Scan from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign grant    = found && !stall_i && rst_ni;
    assign win_addr = req_addr_i[win*ADDRWIDTH +: ADDRWIDTH];
    assign win_data = req_data_i[win*DATAWIDTH +: DATAWIDTH];

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = grant && (win == IW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= '0;
            rf_wdata_o  <= '0;
            grant_idx_o <= '0;
            ptr         <= '0;
        end else if (grant) begin
            // Writes to x0 complete the handshake but never reach the file.
            rf_we_o     <= !((ZERO_REG_EN != 0) && (win_addr == '0));
            rf_waddr_o  <= win_addr;
            rf_wdata_o  <= win_data;
            grant_idx_o <= win;
            ptr         <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        end else begin
            rf_we_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random
// traffic checked against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic [N-1:0]  valid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]  ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [1:0]    gidx;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    int            m_ptr;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_idx;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NREQ(N), .DATAWIDTH(DW), .ADDRWIDTH(AW), .ZERO_REG_EN(1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .stall_i(stall),
        .req_valid_i(valid),
        .req_addr_i(addr),
        .req_data_i(data),
        .req_ready_o(ready),
        .rf_we_o(we),
        .rf_waddr_o(waddr),
        .rf_wdata_o(wdata),
        .grant_idx_o(gidx)
    );

    function automatic int winner(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = winner(valid, m_ptr);
        if (stall || !rst_n || w < 0) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [AW-1:0] a_of(int i);
        return addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(int i);
        return data[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 0;
        m_addr = '0;
        m_data = '0;
        m_idx  = 0;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        int w;
        w = winner(valid, m_ptr);
        if (!stall && rst_n && w >= 0) begin
            m_we   = (a_of(w) != '0);
            m_addr = a_of(w);
            m_data = d_of(w);
            m_idx  = w;
            m_ptr  = (w + 1) % N;
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        valid = '1;
        addr  = {5'd3, 5'd2, 5'd1};
        data  = {32'h33, 32'h22, 32'h11};
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        n_cmp += 5;
        if (ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 000", ready);
        end
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b want 0", we);
        end
        if (waddr !== 5'd0) begin
            n_fail++; $display("FAIL reset_waddr: got %0d want 0", waddr);
        end
        if (wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata);
        end
        if (gidx !== 2'd0) begin
            n_fail++; $display("FAIL reset_gidx: got %0d want 0", gidx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        valid = 3'b010;
        addr  = '0;
        data  = '0;
        addr[1*AW +: AW] = 5'd7;
        data[1*DW +: DW] = 32'hDEADBEEF;
        #2;
        n_cmp++;
        if (ready !== 3'b010) begin
            n_fail++; $display("FAIL single_ready: got %b want 010", ready);
        end
        tick();
        valid = '0;
        n_cmp += 4;
        if (we !== 1'b1) begin
            n_fail++; $display("FAIL single_we: got %b want 1", we);
        end
        if (waddr !== 5'd7) begin
            n_fail++; $display("FAIL single_waddr: got %0d want 7", waddr);
        end
        if (wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_wdata: got %h want deadbeef", wdata);
        end
        if (gidx !== 2'd1) begin
            n_fail++; $display("FAIL single_gidx: got %0d want 1", gidx);
        end
        tick();
        n_cmp += 2;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_we: got %b want 0", we);
        end
        if (waddr !== 5'd7) begin
            n_fail++; $display("FAIL single_hold_waddr: got %0d want 7", waddr);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        valid = '1;
        addr  = {5'd3, 5'd2, 5'd1};
        data  = {32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 6; i++) begin
            #2;
            want = N'(1) << (i % N);
            n_cmp++;
            if (ready !== want) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b want %b", i, ready, want);
            end
            tick();
            n_cmp += 2;
            if (we !== 1'b1) begin
                n_fail++; $display("FAIL rr_we[%0d]: got %b want 1", i, we);
            end
            if (gidx !== 2'(i % N)) begin
                n_fail++;
                $display("FAIL rr_gidx[%0d]: got %0d want %0d", i, gidx, i % N);
            end
        end
        valid = '0;
    endtask

    task automatic test_zero_reg();
        do_reset();
        valid = 3'b001;
        addr  = {5'd3, 5'd2, 5'd0};
        data  = {32'h3, 32'h2, 32'h1};
        #2;
        n_cmp++;
        if (ready !== 3'b001) begin
            n_fail++; $display("FAIL zero_ready: got %b want 001", ready);
        end
        tick();
        n_cmp += 3;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL zero_we: got %b want 0", we);
        end
        if (wdata !== 32'h1) begin
            n_fail++; $display("FAIL zero_wdata: got %h want 1", wdata);
        end
        if (gidx !== 2'd0) begin
            n_fail++; $display("FAIL zero_gidx: got %0d want 0", gidx);
        end
        valid = '1;
        addr  = {5'd3, 5'd2, 5'd1};
        #2;
        n_cmp++;
        if (ready !== 3'b010) begin
            n_fail++; $display("FAIL zero_ptr_adv: got %b want 010", ready);
        end
    endtask

    task automatic test_stall();
        tick();
        stall = 1'b1;
        #2;
        n_cmp += 2;
        if (we !== 1'b1) begin
            n_fail++; $display("FAIL stall_drain_we: got %b want 1", we);
        end
        if (gidx !== 2'd1) begin
            n_fail++; $display("FAIL stall_drain_gidx: got %0d want 1", gidx);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ready !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b want 000", i, ready);
            end
            tick();
            #2;
            n_cmp++;
            if (we !== 1'b0) begin
                n_fail++; $display("FAIL stall_we[%0d]: got %b want 0", i, we);
            end
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 3'b100) begin
            n_fail++; $display("FAIL stall_release: got %b want 100", ready);
        end
        tick();
        n_cmp++;
        if (gidx !== 2'd2 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_after: got idx %0d we %b want idx 2 we 1",
                     gidx, we);
        end
    endtask

    task automatic test_reset_mid();
        valid = '1;
        addr  = {5'd3, 5'd2, 5'd1};
        tick();
        n_cmp++;
        if (we !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_we: got %b want 1", we);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp += 2;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL mid_we_drop: got %b want 0", we);
        end
        if (ready !== 3'b000) begin
            n_fail++; $display("FAIL mid_ready: got %b want 000", ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 3'b001) begin
            n_fail++; $display("FAIL mid_after_ready: got %b want 001", ready);
        end
        tick();
        n_cmp++;
        if (gidx !== 2'd0) begin
            n_fail++; $display("FAIL mid_after_gidx: got %0d want 0", gidx);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] want;
        int           waits [N];
        int           w;
        for (int i = 0; i < N; i++) waits[i] = 0;
        valid = '0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                // keep a pending request stable; occasionally withdraw it
                if (valid[i] && $urandom_range(0, 9) != 0) continue;
                valid[i] = $urandom_range(0, 2) != 0;
                addr[i*AW +: AW] = ($urandom_range(0, 5) == 0) ?
                                   '0 : AW'($urandom);
                data[i*DW +: DW] = $urandom;
                if (!valid[i]) waits[i] = 0;
            end
            #1;
            want = exp_ready();
            n_cmp++;
            if (ready !== want) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, ready, want);
            end
            w = (want != '0) ? winner(valid, m_ptr) : -1;
            tick();
            n_cmp += 3;
            if (we !== m_we) begin
                n_fail++;
                $display("FAIL rand_we[%0d]: got %b want %b", c, we, m_we);
            end
            if (waddr !== m_addr || wdata !== m_data) begin
                n_fail++;
                $display("FAIL rand_wr[%0d]: got %0d/%h want %0d/%h",
                         c, waddr, wdata, m_addr, m_data);
            end
            if (gidx !== 2'(m_idx)) begin
                n_fail++;
                $display("FAIL rand_gidx[%0d]: got %0d want %0d", c, gidx, m_idx);
            end
            for (int i = 0; i < N; i++) begin
                if (i == w) begin
                    waits[i] = 0;
                    valid[i] = 1'b0;
                end else if (w >= 0 && valid[i]) begin
                    waits[i]++;
                end
            end
            n_cmp++;
            if (waits[0] >= N || waits[1] >= N || waits[2] >= N) begin
                n_fail++;
                $display("FAIL rand_fair[%0d]: got waits %0d %0d %0d want < %0d",
                         c, waits[0], waits[1], waits[2], N);
            end
        end
        valid = '0;
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_stall();
        test_reset_mid();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
